scoutfifo: RTL and testbench
============================

Name: scoutfifo

Overview:
- Memory-mapped output-stream peripheral that sits downstream of the single-cycle CPU's data-memory port.
- It decodes the CPU's data address (ALU result), write data (qb) and write enable (wmem).
- CPU stores are buffered in a FIFO and drained to an external consumer over a valid/ready handshake.
- It returns status and control words on a combinational read port, which is muxed with data-memory output at SoC level.

Parameters:
- DEPTH, 8, number of 32-bit FIFO entries; power of two, 2..256.
- BASE_ADDR, 32'hFFFF_0000, word-aligned base of the 16-byte register window.

Ports:
- clk  in  1  clock; all state updates on posedge.
- clr  in  1  synchronous active-high reset.
- addr  in  32  CPU data address.
- wdata  in  32  CPU store data.
- we  in  1  CPU store strobe (wmem).
- sel  out  1  combinational; 1 when addr[31:4] == BASE_ADDR[31:4].
- rdata  out  32  combinational read data; 0 when sel=0.
- out_data  out  32  FIFO head word.
- out_valid  out  1  head valid for the consumer.
- out_ready  in  1  consumer accepts when out_valid and out_ready are both high at posedge.

Behaviour:
- Register map, by addr[3:2]:
  - 0 DATA: write pushes wdata; read returns head word, or 0 if empty; a read never pops.
  - 1 STATUS (read-only): bits [8:0] count, [9] empty, [10] full, [23:16] ovf_cnt, rest 0.
  - 2 CTRL: bit0 en (read/write); bit1 flush (write-1 self-clearing, reads 0); rest 0.
  - 3: reads 0; writes ignored.
  - addr[1:0] ignored.
- Reset: when clr=1 at posedge:
  - count=0, read/write pointers=0, en=0, ovf_cnt=0.
  - out_valid=0 and out_data=0 the following cycle.
  - Reset mid-drain discards all entries and suppresses any transfer that cycle.
- Pop: pop = out_valid & out_ready. out_valid = en & ~empty, combinational from registers.
- Push: push_req = we & sel & (addr[3:2]==0).
  - Accepted if ~full, or if full and pop occurs in the same cycle. A push into a full FIFO with a same-cycle pop is accepted and count stays DEPTH.
  - Otherwise the word is dropped and ovf_cnt increments, saturating at 255.
- Count update: push-only +1; pop-only -1; both: unchanged.
- Pointers: log2(DEPTH) bits, natural wrap; count is a separate register, so full means count == DEPTH.
- Latency: a word pushed at edge N is on out_data and eligible for transfer from cycle N+1 (one-cycle push-to-valid) when en=1. Writing to an empty FIFO with en=1 gives out_valid high the next cycle.
- out_data = storage[rd_ptr], combinational from registered storage. It is stable while out_valid=1 and out_ready=0. Nothing may change head while valid is held, except clr or flush.
- Flush (CTRL write with bit1=1): at that edge, count=0 and rd_ptr=wr_ptr.
  - A same-cycle pop is discarded (consumer sees its transfer, but the state still reflects empty).
  - ovf_cnt is cleared in the same cycle.
  - en takes wdata[0] in the same write.
- en=0 holds the FIFO (out_valid=0); pushes still accepted.
- STATUS/DATA reads reflect pre-edge state. A store and a read cannot occur in the same cycle on this single-port interface.

Decomposition:
- Package scoutfifo_pkg:
  - register offsets: OFF_DATA=2'd0, OFF_STATUS=2'd1, OFF_CTRL=2'd2.
  - STATUS bit positions.
  - CTRL bit positions: EN=0, FLUSH=1.
  - OVF_MAX=8'hFF.
- One sub-module, scfifo (parameter DEPTH, width 32):
  - inputs: push, pop, flush, wdata.
  - outputs: head, count, empty, full.
  - includes the full-with-pop acceptance rule.
- scoutfifo: address decode, CTRL/ovf registers, read mux, handshake.

Test Plan:
- Reset then read STATUS: clr=1 for 2 cycles -> rdata=32'h0000_0200 (empty=1), out_valid=0, sel=0 for addr=32'h0000_0010.
- Order and latency: en=1; store 32'hA, 32'hB, 32'hC to BASE; out_ready=1 -> out_valid rises the cycle after the first store; consumer receives A, B, C in order; STATUS count returns to 0.
- Overflow: en=0; 10 stores with DEPTH=8 -> STATUS=32'h0002_0408 (ovf=2, full, count=8); then en=1, drain -> exactly the first 8 words.
- Full with simultaneous pop: fill 8; hold out_ready=0; then in one cycle out_ready=1 and store 32'h55 -> push accepted, count stays 8, ovf unchanged; 32'h55 emerges last.
- Backpressure: out_ready toggles 0/1 every cycle with 4 queued words -> out_data held constant while out_ready=0; no duplicates or losses.
- Flush and wrap: push 6, pop 5, push 6 (pointers wrap), write CTRL=32'h3 -> next cycle count=0, ovf=0, en=1, out_valid=0; a subsequent store appears correctly.

Source files
------------

// File: rtl/scoutfifo_pkg.sv
// Shared register-map constants and the STATUS word packer for the
// scoutfifo output-stream peripheral.
package scoutfifo_pkg;

  // Word offsets inside the 16-byte register window (addr[3:2])
  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  // STATUS word layout
  localparam int ST_COUNT_LSB = 0;
  localparam int ST_EMPTY     = 9;
  localparam int ST_FULL      = 10;
  localparam int ST_OVF_LSB   = 16;

  // CTRL word layout
  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;

  // Overflow counter saturates here rather than wrapping
  localparam logic [7:0] OVF_MAX = 8'hFF;

  // Assemble the STATUS read word; unused bits stay zero
  function automatic logic [31:0] packStatus(input logic [8:0] count,
                                             input logic       empty,
                                             input logic       full,
                                             input logic [7:0] ovfCnt);
    logic [31:0] word;
    word = '0;
    word[ST_COUNT_LSB +: 9] = count;
    word[ST_EMPTY]          = empty;
    word[ST_FULL]           = full;
    word[ST_OVF_LSB +: 8]   = ovfCnt;
    return word;
  endfunction

endpackage

// File: rtl/scoutfifo_scfifo.sv
// Synchronous FIFO with a separate occupancy counter. A push into a full
// FIFO is still accepted when a pop happens in the same cycle, because the
// head slot is freed at that very edge.
module scfifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     accept
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rdPtr;
  logic [AW-1:0]    r_wrPtr;
  logic [CW-1:0]    r_count;

  assign count  = r_count;
  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign accept = push & ~flush & (~full | pop);
  assign head   = r_mem[r_rdPtr];

  // Storage writes; cleared on reset so the head reads zero afterwards
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (accept) begin
      r_mem[r_wrPtr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties by snapping rd to wr
  always_ff @(posedge clk) begin
    if (clr) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rdPtr <= r_wrPtr;
      r_count <= '0;
    end else begin
      if (accept) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({accept, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/scoutfifo.sv
// Memory-mapped output-stream peripheral: CPU stores to DATA are queued in
// a FIFO and drained to an external consumer over valid/ready. STATUS and
// CTRL are read back on a combinational port.
module scoutfifo
  import scoutfifo_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic        sel,
  output logic [31:0] rdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          w_sel;
  logic [1:0]    w_off;
  logic          w_pushReq;
  logic          w_ctrlWr;
  logic          w_flush;
  logic          w_pop;
  logic          w_accept;
  logic          w_empty;
  logic          w_full;
  logic [CW-1:0] w_count;
  logic [8:0]    w_count9;
  logic [31:0]   w_head;
  logic          w_unused;
  logic          r_en;
  logic [7:0]    r_ovfCnt;

  assign w_sel     = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_off     = addr[3:2];
  assign w_pushReq = we & w_sel & (w_off == OFF_DATA);
  assign w_ctrlWr  = we & w_sel & (w_off == OFF_CTRL);
  assign w_flush   = w_ctrlWr & wdata[CTRL_FLUSH];
  assign w_count9  = 9'(w_count);
  assign w_unused  = ^addr[1:0];

  assign sel       = w_sel;
  assign out_valid = r_en & ~w_empty;
  assign w_pop     = out_valid & out_ready;
  assign out_data  = w_head;

  scfifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk    (clk),
    .clr    (clr),
    .push   (w_pushReq),
    .pop    (w_pop),
    .flush  (w_flush),
    .wdata  (wdata),
    .head   (w_head),
    .count  (w_count),
    .empty  (w_empty),
    .full   (w_full),
    .accept (w_accept)
  );

  // Drain enable, written through CTRL bit0 (also on a flushing write)
  always_ff @(posedge clk) begin
    if (clr) begin
      r_en <= 1'b0;
    end else if (w_ctrlWr) begin
      r_en <= wdata[CTRL_EN];
    end
  end

  // Saturating count of DATA stores dropped because the FIFO was full
  always_ff @(posedge clk) begin
    if (clr || w_flush) begin
      r_ovfCnt <= '0;
    end else if (w_pushReq && !w_accept && (r_ovfCnt != OVF_MAX)) begin
      r_ovfCnt <= r_ovfCnt + 8'd1;
    end
  end

  // Read mux; anything outside the window reads zero so it can be OR-ed
  // with data memory at SoC level
  always_comb begin
    rdata = '0;
    if (w_sel) begin
      case (w_off)
        OFF_DATA:   rdata = w_empty ? 32'd0 : w_head;
        OFF_STATUS: rdata = packStatus(w_count9, w_empty, w_full, r_ovfCnt);
        OFF_CTRL:   rdata = {31'd0, r_en};
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_scoutfifo.sv
// Testbench for scoutfifo: directed scenarios followed by random traffic,
// all checked against a queue-based model of the peripheral.
module tb_scoutfifo;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;

  logic        clk;
  logic        clr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        sel;
  logic [31:0] rdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  // Model state: queued words, enable, overflow count, consumer log
  logic [31:0] mQ[$];
  bit          mEn;
  int          mOvf;
  bit          mKnown;
  logic [31:0] rxLog[$];
  logic [31:0] expRx[$];
  int          checkCount;
  int          passCount;

  scoutfifo #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .sel       (sel),
    .rdata     (rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit inWindow(input logic [31:0] a);
    return a[31:4] == BASE[31:4];
  endfunction

  // What a read of address a should return given the model state
  function automatic logic [31:0] expRdata(input logic [31:0] a);
    logic [31:0] s;
    if (!inWindow(a)) return 32'd0;
    case (a[3:2])
      2'd0: return (mQ.size() == 0) ? 32'd0 : mQ[0];
      2'd1: begin
        s = 32'(mQ.size());
        if (mQ.size() == 0)     s = s | 32'h0000_0200;
        if (mQ.size() == DEPTH) s = s | 32'h0000_0400;
        s = s | (32'(mOvf) << 16);
        return s;
      end
      2'd2: return {31'd0, mEn};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Compare every observable output against the model, mid-cycle
  task automatic checkOutput();
    bit valid;
    check("sel", {31'd0, sel}, {31'd0, inWindow(addr)});
    if (mKnown) begin
      valid = mEn && (mQ.size() > 0);
      check("out_valid", {31'd0, out_valid}, {31'd0, valid});
      if (valid) check("out_data", out_data, mQ[0]);
      check("rdata", rdata, expRdata(addr));
    end
  endtask

  // Advance the model by one clock edge using the inputs now applied
  task automatic modelUpdate();
    bit pop;
    bit pushReq;
    bit ctrlWr;
    int sz;
    if (clr) begin
      mQ.delete();
      mEn    = 1'b0;
      mOvf   = 0;
      mKnown = 1'b1;
      return;
    end
    if (!mKnown) return;
    pop     = mEn && (mQ.size() > 0) && out_ready;
    pushReq = we && inWindow(addr) && (addr[3:2] == 2'd0);
    ctrlWr  = we && inWindow(addr) && (addr[3:2] == 2'd2);
    if (pop) rxLog.push_back(out_data);
    if (ctrlWr) begin
      mEn = wdata[0];
      if (wdata[1]) begin
        mQ.delete();
        mOvf = 0;
        return;
      end
    end
    sz = mQ.size();
    if (pop) void'(mQ.pop_front());
    if (pushReq) begin
      if (sz < DEPTH || pop) mQ.push_back(wdata);
      else if (mOvf < 255) mOvf++;
    end
  endtask

  // One clock cycle: drive, check mid-cycle, step the model, cross the edge
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                               input logic w, input logic r, input logic c);
    addr      = a;
    wdata     = d;
    we        = w;
    out_ready = r;
    clr       = c;
    #4;
    checkOutput();
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] d, input logic r);
    applyStimulus(BASE, d, 1'b1, r, 1'b0);
  endtask

  task automatic writeCtrl(input logic [31:0] d);
    applyStimulus(BASE + 32'h8, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic r);
    applyStimulus(32'h0000_0100, 32'd0, 1'b0, r, 1'b0);
  endtask

  // Read a register with a hard-coded expectation, in addition to the model
  task automatic checkReg(input string tag, input logic [31:0] off, input logic [31:0] exp);
    addr      = BASE + off;
    wdata     = 32'd0;
    we        = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
    #4;
    check(tag, rdata, exp);
    checkOutput();
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  // Compare what the consumer actually received against expRx
  task automatic checkRx(input string tag);
    check({tag, "_len"}, 32'(rxLog.size()), 32'(expRx.size()));
    for (int i = 0; i < expRx.size() && i < rxLog.size(); i++) begin
      check(tag, rxLog[i], expRx[i]);
    end
    rxLog.delete();
    expRx.delete();
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    mKnown     = 1'b0;
    mEn        = 1'b0;
    mOvf       = 0;

    // Reset for two cycles with an address outside the window
    applyStimulus(32'h0000_0010, 32'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h0000_0010, 32'd0, 1'b0, 1'b0, 1'b1);
    check("reset_sel", {31'd0, sel}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkReg("reset_status", 32'h4, 32'h0000_0200);

    // Order and latency
    writeCtrl(32'h1);
    store(32'hA, 1'b1);
    check("valid_after_store", {31'd0, out_valid}, 32'd1);
    store(32'hB, 1'b1);
    store(32'hC, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    expRx = '{32'hA, 32'hB, 32'hC};
    checkRx("order");
    checkReg("drained_status", 32'h4, 32'h0000_0200);

    // Overflow while held, then drain
    writeCtrl(32'h0);
    for (int i = 0; i < 10; i++) store(32'd100 + 32'(i), 1'b1);
    checkReg("ovf_status", 32'h4, 32'h0002_0408);
    writeCtrl(32'h1);
    for (int i = 0; i < 10; i++) idle(1'b1);
    for (int i = 0; i < 8; i++) expRx.push_back(32'd100 + 32'(i));
    checkRx("ovf_drain");

    // Full FIFO with a simultaneous pop accepts the store
    writeCtrl(32'h3);
    for (int i = 0; i < 8; i++) store(32'd200 + 32'(i), 1'b0);
    store(32'h55, 1'b1);
    checkReg("full_pop_status", 32'h4, 32'h0000_0408);
    for (int i = 0; i < 10; i++) idle(1'b1);
    for (int i = 0; i < 8; i++) expRx.push_back(32'd200 + 32'(i));
    expRx.push_back(32'h55);
    checkRx("full_pop");

    // Backpressure with ready toggling every cycle
    for (int i = 0; i < 4; i++) store(32'd300 + 32'(i), 1'b0);
    for (int i = 0; i < 12; i++) idle(logic'(i % 2));
    for (int i = 0; i < 4; i++) expRx.push_back(32'd300 + 32'(i));
    checkRx("backpressure");

    // Pointer wrap followed by flush
    writeCtrl(32'h3);
    for (int i = 0; i < 6; i++) store(32'd400 + 32'(i), 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    for (int i = 0; i < 6; i++) store(32'd410 + 32'(i), 1'b0);
    for (int i = 0; i < 5; i++) expRx.push_back(32'd400 + 32'(i));
    checkRx("wrap_pop");
    writeCtrl(32'h3);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    checkReg("flush_status", 32'h4, 32'h0000_0200);
    checkReg("flush_ctrl", 32'h8, 32'h0000_0001);
    store(32'h77, 1'b0);
    idle(1'b1);
    idle(1'b1);
    expRx.push_back(32'h77);
    checkRx("after_flush");

    // Random traffic, including rare flushes and resets
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      logic [1:0]  off;
      logic        c;
      logic        w;
      logic        r;
      int          kind;
      c    = ($urandom_range(0, 99) == 0);
      kind = $urandom_range(0, 9);
      off  = (kind < 5) ? 2'd0 : 2'($urandom_range(1, 3));
      a    = BASE | {26'd0, off, 2'($urandom_range(0, 3))};
      if (kind >= 8) a = $urandom;
      d = $urandom;
      if (inWindow(a) && a[3:2] == 2'd2)
        d = {30'd0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)};
      w = logic'($urandom_range(0, 1));
      r = logic'($urandom_range(0, 1));
      applyStimulus(a, d, w, r, c);
    end
    rxLog.delete();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
